tmds_encoder: RTL and testbench



---
 rtl/tmds_encoder.sv | 146 ++++++++++++++
 tb/tb_tmds_encoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_encoder
// Purpose  : Per-channel DVI TMDS 8b/10b encoder, 3-stage pipeline.
//            Optional TMDS_DISP_OUT_EN exposes the running disparity (disp_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module tmds_encoder #(
  parameter int CNT_W = 6
) (
  input  logic             pixel_clk,
  input  logic             reset_n,
  input  logic [7:0]       data,
  input  logic             blank,
  input  logic             c0,
  input  logic             c1,
`ifdef TMDS_DISP_OUT_EN
  output logic [CNT_W-1:0] disp_cnt,
`endif
  output logic [9:0]       q_out
);

  localparam logic [9:0] c_ctrl_00 = 10'b1101010100;
  localparam logic [9:0] c_ctrl_01 = 10'b0010101011;
  localparam logic [9:0] c_ctrl_10 = 10'b0101010100;
  localparam logic [9:0] c_ctrl_11 = 10'b1010101011;
  localparam logic signed [CNT_W-1:0] c_two = CNT_W'(2);

  // Stage 1: register inputs and the ones-count of the pixel
  logic [7:0] r_s1_data;
  logic       r_s1_de, r_s1_c0, r_s1_c1;
  logic [3:0] r_s1_n1d;
  logic [3:0] w_n1d;

  always_comb begin
    w_n1d = 4'd0;
    for (int i = 0; i < 8; i++) w_n1d = w_n1d + {3'b000, data[i]};
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_data <= 8'd0;
      r_s1_de   <= 1'b0;
      r_s1_c0   <= 1'b0;
      r_s1_c1   <= 1'b0;
      r_s1_n1d  <= 4'd0;
    end else begin
      r_s1_data <= data;
      r_s1_de   <= ~blank;
      r_s1_c0   <= c0;
      r_s1_c1   <= c1;
      r_s1_n1d  <= w_n1d;
    end
  end

  // Stage 2: transition-minimised word q_m
  logic       w_use_xnor;
  logic [8:0] w_qm;
  logic [8:0] r_s2_qm;
  logic       r_s2_de, r_s2_c0, r_s2_c1;

  assign w_use_xnor = (r_s1_n1d > 4'd4) || ((r_s1_n1d == 4'd4) && !r_s1_data[0]);

  always_comb begin
    w_qm    = 9'd0;
    w_qm[0] = r_s1_data[0];
    for (int i = 1; i < 8; i++)
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ r_s1_data[i]) : (w_qm[i-1] ^ r_s1_data[i]);
    w_qm[8] = ~w_use_xnor;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_qm <= 9'd0;
      r_s2_de <= 1'b0;
      r_s2_c0 <= 1'b0;
      r_s2_c1 <= 1'b0;
    end else begin
      r_s2_qm <= w_qm;
      r_s2_de <= r_s1_de;
      r_s2_c0 <= r_s1_c0;
      r_s2_c1 <= r_s1_c1;
    end
  end

  // Stage 3: DC balancing against the signed running disparity
  logic signed [CNT_W-1:0] r_cnt;
  logic signed [CNT_W-1:0] w_cnt_next;
  logic signed [CNT_W-1:0] w_diff;
  logic [3:0]              w_n1q, w_n0q;
  logic [9:0]              w_q_next;
  logic                    w_case_a, w_case_b, w_qm8;

  always_comb begin
    w_n1q = 4'd0;
    for (int i = 0; i < 8; i++) w_n1q = w_n1q + {3'b000, r_s2_qm[i]};
  end

  assign w_n0q  = 4'd8 - w_n1q;
  assign w_diff = $signed({{(CNT_W-4){1'b0}}, w_n1q}) - $signed({{(CNT_W-4){1'b0}}, w_n0q});
  assign w_qm8  = r_s2_qm[8];

  assign w_case_a = (r_cnt == '0) || (w_n1q == w_n0q);
  assign w_case_b = (!r_cnt[CNT_W-1] && (r_cnt != '0) && (w_n1q > w_n0q)) ||
                    ( r_cnt[CNT_W-1] && (w_n0q > w_n1q));

  always_comb begin
    w_q_next   = c_ctrl_00;
    w_cnt_next = '0;
    if (r_s2_de) begin
      if (w_case_a) begin
        w_q_next   = {~w_qm8, w_qm8, w_qm8 ? r_s2_qm[7:0] : ~r_s2_qm[7:0]};
        w_cnt_next = w_qm8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
      end else if (w_case_b) begin
        w_q_next   = {1'b1, w_qm8, ~r_s2_qm[7:0]};
        w_cnt_next = r_cnt + (w_qm8 ? c_two : '0) - w_diff;
      end else begin
        w_q_next   = {1'b0, w_qm8, r_s2_qm[7:0]};
        w_cnt_next = r_cnt - (w_qm8 ? '0 : c_two) + w_diff;
      end
    end else begin
      case ({r_s2_c1, r_s2_c0})
        2'b00:   w_q_next = c_ctrl_00;
        2'b01:   w_q_next = c_ctrl_01;
        2'b10:   w_q_next = c_ctrl_10;
        default: w_q_next = c_ctrl_11;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      q_out <= c_ctrl_00;
      r_cnt <= '0;
    end else begin
      q_out <= w_q_next;
      r_cnt <= w_cnt_next;
    end
  end

`ifdef TMDS_DISP_OUT_EN
  assign disp_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_encoder
// Purpose  : Randomised and directed checks of tmds_encoder against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_encoder;

  localparam int CNT_W = 6;
  localparam logic [9:0] c_tok [4]   = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  localparam logic [9:0] c_z_q [4]   = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
  localparam int         c_z_cnt [4] = '{-8, 2, -6, 4};

  typedef struct {
    logic [9:0] q;
    int         cnt;
  } exp_t;

  logic       pixel_clk = 1'b0;
  logic       reset_n;
  logic [7:0] data;
  logic       blank, c0, c1;
  logic [9:0] q_out;
`ifdef TMDS_DISP_OUT_EN
  logic [CNT_W-1:0] disp_cnt;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_cnt   = 0;
  exp_t exp_q[$];
  int   hist_q[$];
  int   hist_c[$];

  tmds_encoder #(.CNT_W(CNT_W)) dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .data      (data),
    .blank     (blank),
    .c0        (c0),
    .c1        (c1),
`ifdef TMDS_DISP_OUT_EN
    .disp_cnt  (disp_cnt),
`endif
    .q_out     (q_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  // Reference: DVI encoding rules evaluated in input order with an integer disparity.
  task automatic ref_push(input logic bl, input logic [7:0] d, input logic k0, input logic k1);
    exp_t e;
    int   ones, n1q, n0q, qm8;
    logic [8:0] qm;
    bit   use_xnor;
    if (bl) begin
      m_cnt = 0;
      e.q   = c_tok[{k1, k0}];
    end else begin
      ones     = $countones(d);
      use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm       = '0;
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++)
        qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~use_xnor;
      qm8   = use_xnor ? 0 : 1;
      n1q   = $countones(qm[7:0]);
      n0q   = 8 - n1q;
      if (m_cnt == 0 || n1q == n0q) begin
        e.q   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        m_cnt = m_cnt + ((qm8 == 1) ? (n1q - n0q) : (n0q - n1q));
      end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
        e.q   = {1'b1, qm[8], ~qm[7:0]};
        m_cnt = m_cnt + 2 * qm8 + (n0q - n1q);
      end else begin
        e.q   = {1'b0, qm[8], qm[7:0]};
        m_cnt = m_cnt - 2 * (1 - qm8) + (n1q - n0q);
      end
    end
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic bl, input logic [7:0] d, input logic k0, input logic k1);
    exp_t e;
    int   oq, oc;
    blank = bl;
    data  = d;
    c0    = k0;
    c1    = k1;
    @(posedge pixel_clk);
    #1;
    oq = int'(q_out);
    oc = int'(dut.r_cnt);
    hist_q.push_back(oq);
    hist_c.push_back(oc);
    if (reset_n) begin
      ref_push(bl, d, k0, k1);
      e = exp_q.pop_front();
      check("q_model", oq, int'(e.q));
      check("cnt_model", oc, e.cnt);
      check("cnt_range", (oc >= -10 && oc <= 10) ? 1 : 0, 1);
`ifdef TMDS_DISP_OUT_EN
      check("disp_cnt", int'($signed(disp_cnt)), e.cnt);
`endif
    end
  endtask

  // Asynchronous reset pulse spanning one rising edge.
  task automatic do_reset();
    exp_t e;
    #2 reset_n = 1'b0;
    #1;
    check("rst_q_async", int'(q_out), 'h354);
    check("rst_cnt_async", int'(dut.r_cnt), 0);
    m_cnt = 0;
    exp_q.delete();
    e.q   = 10'h354;
    e.cnt = 0;
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(posedge pixel_clk);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b1;
    blank   = 1'b0;
    data    = 8'hAA;
    c0      = 1'b0;
    c1      = 1'b0;
    #1;
    do_reset();

    // Control token held while the pipeline refills after reset
    hist_q.delete();
    hist_c.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 8'hAA, 1'b0, 1'b0);
    check("rst_hold0", hist_q[0], 'h354);
    check("rst_hold1", hist_q[1], 'h354);
    check("rst_active", (hist_q[2] != 'h354) ? 1 : 0, 1);

    // Control token sweep with junk data during blanking
    hist_q.delete();
    hist_c.delete();
    for (int t = 0; t < 4; t++) begin
      logic [1:0] tv;
      tv = 2'(t);
      step(1'b1, 8'($urandom), tv[0], tv[1]);
    end
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) check("ctrl_tok", hist_q[t+2], int'(c_tok[t]));

    // 0x00 stream from zero disparity
    hist_q.delete();
    hist_c.delete();
    step(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("d00_q", hist_q[i+3], int'(c_z_q[i]));
      check("d00_cnt", hist_c[i+3], c_z_cnt[i]);
    end

    // Two 0xFF pixels after blanking, then blank clears disparity
    hist_q.delete();
    hist_c.delete();
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 1'b1);
    step(1'b0, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("dff1_q", hist_q[3], 'h200);
    check("dff1_cnt", hist_c[3], -8);
    check("dff2_q", hist_q[4], 'h0FF);
    check("dff2_cnt", hist_c[4], -2);
    check("dff_blank_cnt", hist_c[5], 0);

    // Long random active run then blanking
    hist_q.delete();
    hist_c.delete();
    for (int i = 0; i < 1024; i++) step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    check("rand_blank_cnt", hist_c[1026], 0);

    // Mixed traffic with a mid-stream reset pulse
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      step(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
